// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width calculation and parameter-legality checks
// for the parametrised FIFO family.
package fifo_pkg;

  // Ceiling log2 for constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Default geometry of the family; module instances derive their own widths
  // from their DEPTH parameter through the helpers below.
  localparam int DEFAULT_DEPTH = 16;
  localparam int PTR_W = clog2(DEFAULT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Pointer width for a given depth.
  function automatic int fifo_ptr_w(input int depth);
    return clog2(depth);
  endfunction

  // Count width: one bit wider than the pointers so DEPTH itself is representable.
  function automatic int fifo_cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  // DEPTH must be a power of two and at least 2.
  function automatic bit fifo_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Almost-full threshold in 1..DEPTH, almost-empty threshold in 0..DEPTH-1.
  function automatic bit fifo_thresh_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fwft_fifo_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port,
// written so the array maps onto distributed RAM. Contents are never reset.
module fwft_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = fifo_ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the incoming word on an enabled edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read gives the head word without a read request.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fwft_fifo_param.sv
// Parametrised first-word-fall-through synchronous FIFO with occupancy count,
// almost-full/almost-empty thresholds and overflow/underflow pulses.
// Optional macro FWFT_FIFO_FLUSH_EN adds a 'flush' input that empties the
// queue (pointers and count) without touching memory.
module fwft_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef FWFT_FIFO_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic [DATA_W-1:0]           din,
  input  logic                        wr_en,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           dout,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [fifo_cnt_w(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  // Elaboration-time guard against illegal geometry.
  if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
    $error("fwft_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!fifo_thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("fwft_fifo_param: AF_THRESH/AE_THRESH out of range");
  end

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, underflow_reg;
  logic             wr_acc, rd_acc;
  logic             clear;

`ifdef FWFT_FIFO_FLUSH_EN
  assign clear = rst | flush;
`else
  assign clear = rst;
`endif

  // Status flags come straight from the registered count.
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == FULL_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign almost_full  = (count_reg >= AF_CNT);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A read frees a slot in the same cycle, so a full FIFO can still accept
  // a write alongside it.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  fwft_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we      (wr_acc & ~clear),
    .wr_addr (wr_ptr_reg),
    .wr_data (din),
    .rd_addr (rd_ptr_reg),
    .rd_data (dout)
  );

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_acc) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // State registers; reset and flush both empty the queue without error pulses.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= wr_en & ~wr_acc;
      underflow_reg <= rd_en & ~rd_acc;
    end
  end

endmodule

// File: tb/tb_fwft_fifo_param.sv
// Directed self-checking bench for fwft_fifo_param (default parameters).
// Exercises the flush path too when FWFT_FIFO_FLUSH_EN is defined.
module tb_fwft_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [DATA_W-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [DATA_W-1:0] dout;
  logic             empty, full, almost_empty, almost_full;
  logic [4:0]       count;
  logic             overflow, underflow;

  int n_checks = 0;
  int n_pass   = 0;

  fwft_fifo_param #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FWFT_FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and sample 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    rst = 1'b0;
    step(0, 0, 8'h00);

    // Reset then idle
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);

    // Basic FWFT latency and pop
    step(1, 0, 8'h64);
    check("fwft_dout", 32'(dout), 32'h64);
    check("fwft_empty", 32'(empty), 32'd0);
    check("fwft_cnt1", 32'(count), 32'd1);
    step(1, 0, 8'h2D);
    check("fwft_head_kept", 32'(dout), 32'h64);
    check("fwft_cnt2", 32'(count), 32'd2);
    step(0, 1, 8'h00);
    check("pop_dout", 32'(dout), 32'h2D);
    check("pop_cnt", 32'(count), 32'd1);
    step(0, 1, 8'h00);
    check("pop_empty", 32'(empty), 32'd1);

    // Fill to full (pointers start at 2, so this wraps)
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 8'(i));
      check($sformatf("fill_cnt%0d", i + 1), 32'(count), 32'(i + 1));
      check($sformatf("fill_ae%0d", i + 1), 32'(almost_empty), ((i + 1) <= 2) ? 32'd1 : 32'd0);
      check($sformatf("fill_af%0d", i + 1), 32'(almost_full), ((i + 1) >= 14) ? 32'd1 : 32'd0);
      check($sformatf("fill_full%0d", i + 1), 32'(full), ((i + 1) == 16) ? 32'd1 : 32'd0);
    end
    step(1, 0, 8'h99);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(count), 32'd16);
    check("ovf_head", 32'(dout), 32'h00);
    step(0, 0, 8'h00);
    check("ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_dout%0d", i), 32'(dout), 32'(i));
      step(0, 1, 8'h00);
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_unf", 32'(underflow), 32'd0);

    // Full with simultaneous read and write
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'hAA);
      check($sformatf("rw_full_cnt%0d", i), 32'(count), 32'd16);
      check($sformatf("rw_full_flag%0d", i), 32'(full), 32'd1);
      check($sformatf("rw_full_ovf%0d", i), 32'(overflow), 32'd0);
    end
    for (int i = 3; i < DEPTH; i++) begin
      check($sformatf("rw_dout%0d", i), 32'(dout), 32'(i));
      step(0, 1, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rw_aa%0d", i), 32'(dout), 32'hAA);
      step(0, 1, 8'h00);
    end
    check("rw_empty", 32'(empty), 32'd1);

    // Underflow cases
    step(0, 1, 8'h00);
    check("unf_pulse", 32'(underflow), 32'd1);
    check("unf_cnt", 32'(count), 32'd0);
    step(0, 0, 8'h00);
    check("unf_clear", 32'(underflow), 32'd0);
    step(1, 1, 8'h55);
    check("unf_rw_pulse", 32'(underflow), 32'd1);
    check("unf_rw_cnt", 32'(count), 32'd1);
    check("unf_rw_dout", 32'(dout), 32'h55);
    step(0, 1, 8'h00);
    check("unf_rw_drain", 32'(count), 32'd0);

    // Reset mid-operation with a write pending
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h10 + i));
    check("load5_cnt", 32'(count), 32'd5);
    rst = 1'b1;
    step(1, 0, 8'h77);
    rst = 1'b0;
    check("mrst_cnt", 32'(count), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_ae", 32'(almost_empty), 32'd1);
    check("mrst_ovf", 32'(overflow), 32'd0);
    step(1, 0, 8'h33);
    check("mrst_wr_dout", 32'(dout), 32'h33);
    check("mrst_wr_cnt", 32'(count), 32'd1);
    step(0, 1, 8'h00);

`ifdef FWFT_FIFO_FLUSH_EN
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h20 + i));
    flush = 1'b1;
    step(1, 1, 8'h88);
    flush = 1'b0;
    check("flush_cnt", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_ae", 32'(almost_empty), 32'd1);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_unf", 32'(underflow), 32'd0);
    step(1, 0, 8'h44);
    check("flush_wr_dout", 32'(dout), 32'h44);
    check("flush_wr_cnt", 32'(count), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwft_fifo_param.md
Name: fwft_fifo_param

Overview:
- Parametrised first-word-fall-through synchronous FIFO; next generation of the team's fixed 4-bit FWFT FIFO.
- Adds configurable width and depth, occupancy count, almost-full/almost-empty thresholds, and overflow/underflow error pulses.
- Sits between producer/consumer stages inside the shared buffer; the head word is always presented on dout without a read request.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_W  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read/pop request; acknowledges the word currently on dout.
- dout  out  DATA_W  head-of-queue word; valid whenever empty=0.
- empty  out  1  no entries stored.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=1 at a rising edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1), overflow=0, underflow=0.
- dout is unspecified while empty=1. Memory contents are not cleared by reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is a registered counter, one bit wider than the pointers. All status flags derive from the registered count, so they update on the same edge as count.
- Write acceptance: wr_acc = wr_en & (~full | rd_acc).
  - On an accepted write, mem[wr_ptr] <= din and wr_ptr increments.
- Read acceptance: rd_acc = rd_en & ~empty.
  - On an accepted read, rd_ptr increments.
- FWFT: dout = mem[rd_ptr] (asynchronous read of the storage).
  - A word written into an empty FIFO at edge N is on dout, with empty=0, immediately after edge N. Write-to-dout latency is 1 cycle.
  - No same-cycle bypass from din to dout.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with rd_en and wr_en both high: both accepted, count stays DEPTH, full stays 1.
- Empty with rd_en and wr_en both high: write accepted, read rejected, underflow pulses, count becomes 1.
- overflow <= wr_en & ~wr_acc. underflow <= rd_en & ~rd_acc. Both are registered and high for exactly one cycle per rejected request.
- A rejected operation changes no other state.
- rst asserted mid-operation discards all contents at that edge; wr_en/rd_en are ignored in the reset cycle.

Optional Feature:
- Macro FWFT_FIFO_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit, placed after rst).
  - flush=1 at an edge sets pointers and count to 0, same as reset but with memory untouched.
  - Takes priority over wr_en/rd_en in that cycle; produces no overflow/underflow pulse.
  - Flags show the empty state after that edge.
- Undefined: no flush port; behaviour exactly as above.

Decomposition:
- Shared package fifo_pkg:
  - clog2 constant function.
  - Localparams for pointer width (PTR_W) and count width (CNT_W).
  - Parameter-legality checks (power-of-two DEPTH, threshold ranges), reused by future FIFO variants.
- Sub-module fwft_fifo_mem: DEPTH x DATA_W array with one synchronous write port and one asynchronous read port. Keeps storage inferable as distributed RAM.
- Pointer, count and flag logic stays in the top module.

Test Plan (defaults: DATA_W=8, DEPTH=16, AF=14, AE=2):
- Reset then idle -> empty=1, count=0, almost_empty=1, full=0, overflow=underflow=0.
- Write 0x64 then 0x2D on consecutive cycles -> dout=0x64 one cycle after the first write edge; count=2; after one rd_en pulse, dout=0x2D, count=1.
- Write 16 words 0x00..0x0F, then one more write with rd_en=0 -> almost_full=1 at count 14, full=1 at 16; overflow pulses one cycle; a full read-out yields 0x00..0x0F in order (pointer wrap checked on the second pass).
- Full, then rd_en=wr_en=1 with din=0xAA for 3 cycles -> count stays 16, no overflow, the next reads return 0x03.. and the 0xAA words last.
- Empty, then rd_en=1 alone -> underflow pulses one cycle, count stays 0; rd_en=wr_en=1 with din=0x55 -> underflow pulses, count=1, dout=0x55.
- Load 5 words, assert rst for one cycle with wr_en=1 -> count=0, empty=1; with FWFT_FIFO_FLUSH_EN, repeat using flush and check identical flags and no error pulse.
